// File: rtl/ysyx_040729_mem_lsu.sv
// ysyx_040729_mem_lsu -- MEM-stage load/store unit.
//
// Takes the effective address and store data from EXE, runs one transaction
// at a time on a 64-bit aligned data-memory bus (request/grant/response) and
// returns sign- or zero-extended load data to WB. The upstream pipeline is
// stalled while a transaction is outstanding.
//
// Optional feature macro: YSYX_040729_LSU_MISALIGN_TRAP_EN
//   defined   : a misaligned request in IDLE is refused with a one-cycle
//               misalign_o pulse and no bus activity.
//   undefined : misalign_o is tied low and the access is aligned down to
//               its natural size.
//
// Ports
//   clock, reset        rising-edge clock, asynchronous active-high reset
//   req_valid_i         MEM stage holds a load or store
//   req_wen_i           1 = store, 0 = load
//   req_func3_i         RISC-V funct3 ([1:0] size, [2] unsigned load)
//   req_addr_i          effective address
//   req_wdata_i         store data
//   stall_o             hold IF/ID/EXE/MEM pipeline registers
//   rdata_o             extended load result
//   rdata_valid_o       one-cycle pulse when a load completes
//   misalign_o          one-cycle pulse on a trapped misaligned request
//   dmem_req_o .. dmem_wstrb_o   bus request side
//   dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i   bus grant / response side
module ysyx_040729_mem_lsu #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid_i,
  input  logic                  req_wen_i,
  input  logic [2:0]            req_func3_i,
  input  logic [ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0] req_wdata_i,
  output logic                  stall_o,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  rdata_valid_o,
  output logic                  misalign_o,
  output logic                  dmem_req_o,
  output logic                  dmem_wen_o,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  output logic [7:0]            dmem_wstrb_o,
  input  logic                  dmem_gnt_i,
  input  logic                  dmem_rvalid_i,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t state, state_nxt;

  logic                  wen_p0;
  logic [2:0]            func3_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [DATA_WIDTH-1:0] wdata_p0;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  capture;
  logic                  complete;
  logic                  load_done;
  logic [2:0]            off_p0;
  logic [DATA_WIDTH-1:0] lane_data;
  logic [DATA_WIDTH-1:0] load_ext_data;

  // Low address bits that must be zero for a naturally aligned access.
  function automatic logic [2:0] size_mask(input logic [1:0] size);
    case (size)
      2'd0:    return 3'b000;
      2'd1:    return 3'b001;
      2'd2:    return 3'b011;
      default: return 3'b111;
    endcase
  endfunction

  function automatic logic [DATA_WIDTH-1:0] load_ext(input logic [2:0]            f3,
                                                     input logic [DATA_WIDTH-1:0] d);
    case (f3)
      3'b000:  return DATA_WIDTH'($signed(d[7:0]));
      3'b001:  return DATA_WIDTH'($signed(d[15:0]));
      3'b010:  return DATA_WIDTH'($signed(d[31:0]));
      3'b100:  return DATA_WIDTH'(d[7:0]);
      3'b101:  return DATA_WIDTH'(d[15:0]);
      3'b110:  return DATA_WIDTH'(d[31:0]);
      default: return d;
    endcase
  endfunction

  function automatic logic [7:0] store_strb(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] base;
    case (size)
      2'd0:    base = 8'h01;
      2'd1:    base = 8'h03;
      2'd2:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

  // Replicating the operand across every lane means the strobes alone pick
  // the destination bytes, with no data shifter.
  function automatic logic [DATA_WIDTH-1:0] store_rep(input logic [1:0]            size,
                                                      input logic [DATA_WIDTH-1:0] w);
    case (size)
      2'd0:    return {(DATA_WIDTH/8){w[7:0]}};
      2'd1:    return {(DATA_WIDTH/16){w[15:0]}};
      2'd2:    return {(DATA_WIDTH/32){w[31:0]}};
      default: return w;
    endcase
  endfunction

`ifdef YSYX_040729_LSU_MISALIGN_TRAP_EN
  assign misalign_o = (state == IDLE) && req_valid_i &&
                      (|(req_addr_i[2:0] & size_mask(req_func3_i[1:0])));
`else
  assign misalign_o = 1'b0;
`endif

  assign capture   = (state == IDLE) && req_valid_i && !misalign_o;
  assign complete  = (state == RESP) && dmem_rvalid_i;
  assign load_done = complete && !wen_p0;

  // Aligning the offset down is a no-op for trapped builds, since misaligned
  // requests never get captured there.
  assign off_p0        = addr_p0[2:0] & ~size_mask(func3_p0[1:0]);
  assign lane_data     = dmem_rdata_i >> {off_p0, 3'b000};
  assign load_ext_data = load_ext(func3_p0, lane_data);

  assign stall_o       = req_valid_i && !complete && !misalign_o;
  assign rdata_valid_o = load_done;
  assign rdata_o       = load_done ? load_ext_data : rdata_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rdata_q <= '0;
    end else begin
      state <= state_nxt;
      if (load_done) rdata_q <= load_ext_data;
    end
  end

  // Stage p0: request captured in IDLE, held for the whole transaction.
  always_ff @(posedge clock) begin
    if (capture) begin
      wen_p0   <= req_wen_i;
      func3_p0 <= req_func3_i;
      addr_p0  <= req_addr_i;
      wdata_p0 <= req_wdata_i;
    end
  end

  always_comb begin
    state_nxt    = state;
    dmem_req_o   = 1'b0;
    dmem_wen_o   = 1'b0;
    dmem_addr_o  = '0;
    dmem_wdata_o = '0;
    dmem_wstrb_o = '0;
    case (state)
      IDLE: begin
        if (capture) state_nxt = REQ;
      end
      REQ: begin
        dmem_req_o   = 1'b1;
        dmem_wen_o   = wen_p0;
        dmem_addr_o  = {addr_p0[ADDR_WIDTH-1:3], 3'b000};
        dmem_wdata_o = store_rep(func3_p0[1:0], wdata_p0);
        dmem_wstrb_o = store_strb(func3_p0[1:0], off_p0);
        if (dmem_gnt_i) state_nxt = RESP;
      end
      RESP: begin
        if (dmem_rvalid_i) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ysyx_040729_mem_lsu.sv
module tb_ysyx_040729_mem_lsu;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid_i;
  logic        req_wen_i;
  logic [2:0]  req_func3_i;
  logic [63:0] req_addr_i;
  logic [63:0] req_wdata_i;
  logic        stall_o;
  logic [63:0] rdata_o;
  logic        rdata_valid_o;
  logic        misalign_o;
  logic        dmem_req_o;
  logic        dmem_wen_o;
  logic [63:0] dmem_addr_o;
  logic [63:0] dmem_wdata_o;
  logic [7:0]  dmem_wstrb_o;
  logic        dmem_gnt_i;
  logic        dmem_rvalid_i;
  logic [63:0] dmem_rdata_i;

  int          total = 0;
  int          bad   = 0;
  logic [63:0] last_load = '0;

  always #5 clock = ~clock;

  ysyx_040729_mem_lsu #(.DATA_WIDTH(64), .ADDR_WIDTH(64)) dut (
    .clock(clock), .reset(reset),
    .req_valid_i(req_valid_i), .req_wen_i(req_wen_i), .req_func3_i(req_func3_i),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .stall_o(stall_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
    .misalign_o(misalign_o),
    .dmem_req_o(dmem_req_o), .dmem_wen_o(dmem_wen_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_wstrb_o(dmem_wstrb_o),
    .dmem_gnt_i(dmem_gnt_i), .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // Reference model: byte-level view of the access.
  function automatic int access_off(input logic [2:0] f3, input logic [63:0] a);
    int n;
    int off;
    n   = 1 << f3[1:0];
    off = int'(a[2:0]);
    return off - (off % n);
  endfunction

  function automatic logic [63:0] ref_load(input logic [2:0] f3, input logic [63:0] a,
                                           input logic [63:0] rd);
    int n;
    int off;
    logic [63:0] v;
    n   = 1 << f3[1:0];
    off = access_off(f3, a);
    v   = '0;
    for (int k = 0; k < n; k++)
      v = v | (((rd >> (8 * (off + k))) & 64'hFF) << (8 * k));
    if (!f3[2] && n < 8 && v[8*n-1])
      v = v - (64'd1 << (8 * n));
    return v;
  endfunction

  function automatic logic [7:0] ref_strb(input logic [2:0] f3, input logic [63:0] a);
    int n;
    int off;
    logic [7:0] s;
    n   = 1 << f3[1:0];
    off = access_off(f3, a);
    s   = '0;
    for (int k = 0; k < n; k++) s[off+k] = 1'b1;
    return s;
  endfunction

  function automatic logic [63:0] ref_wdata(input logic [2:0] f3, input logic [63:0] wd);
    int n;
    logic [63:0] v;
    n = 1 << f3[1:0];
    v = '0;
    for (int i = 0; i < 8; i++)
      v = v | (((wd >> (8 * (i % n))) & 64'hFF) << (8 * i));
    return v;
  endfunction

  task automatic do_txn(input string tag, input logic wen, input logic [2:0] f3,
                        input logic [63:0] a, input logic [63:0] wd, input logic [63:0] rd,
                        input int gw, input int rw);
    logic [63:0] exp_rd;
    logic        mis;
    int          n;
    n      = 1 << f3[1:0];
    mis    = (int'(a[2:0]) % n) != 0;
    exp_rd = ref_load(f3, a, rd);

    @(negedge clock);
    req_valid_i   = 1'b1;
    req_wen_i     = wen;
    req_func3_i   = f3;
    req_addr_i    = a;
    req_wdata_i   = wd;
    dmem_gnt_i    = 1'($urandom);
    dmem_rvalid_i = 1'($urandom);
    dmem_rdata_i  = rnd64();
    #1;
`ifdef YSYX_040729_LSU_MISALIGN_TRAP_EN
    if (mis) begin
      check({tag, "_mis_pulse"}, misalign_o, 1);
      check({tag, "_mis_stall"}, stall_o, 0);
      check({tag, "_mis_req"}, dmem_req_o, 0);
      @(negedge clock);
      req_valid_i = 1'b0;
      #1;
      check({tag, "_mis_pulse_end"}, misalign_o, 0);
      check({tag, "_mis_idle_req"}, dmem_req_o, 0);
      return;
    end
`endif
    check({tag, "_cap_stall"}, stall_o, 1);
    check({tag, "_cap_misalign"}, misalign_o, 0);
    check({tag, "_cap_req"}, dmem_req_o, 0);
    check({tag, "_cap_rvld"}, rdata_valid_o, 0);

    for (int g = 0; g <= gw; g++) begin
      @(negedge clock);
      dmem_gnt_i    = (g == gw);
      dmem_rvalid_i = 1'($urandom);
      dmem_rdata_i  = rnd64();
      req_addr_i    = rnd64();
      req_wdata_i   = rnd64();
      #1;
      check({tag, "_req"}, dmem_req_o, 1);
      check({tag, "_addr"}, dmem_addr_o, {a[63:3], 3'b000});
      check({tag, "_wen"}, dmem_wen_o, wen);
      check({tag, "_req_stall"}, stall_o, 1);
      check({tag, "_req_rvld"}, rdata_valid_o, 0);
      check({tag, "_req_rdata"}, rdata_o, last_load);
      if (wen) begin
        check({tag, "_wstrb"}, dmem_wstrb_o, ref_strb(f3, a));
        check({tag, "_wdata"}, dmem_wdata_o, ref_wdata(f3, wd));
      end
    end

    for (int r = 0; r <= rw; r++) begin
      @(negedge clock);
      dmem_gnt_i    = 1'($urandom);
      dmem_rvalid_i = (r == rw);
      dmem_rdata_i  = (r == rw) ? rd : rnd64();
      #1;
      if (r == rw && !wen) last_load = exp_rd;
      check({tag, "_resp_req"}, dmem_req_o, 0);
      check({tag, "_resp_stall"}, stall_o, (r == rw) ? 0 : 1);
      check({tag, "_resp_rvld"}, rdata_valid_o, (r == rw && !wen) ? 1 : 0);
      check({tag, "_resp_rdata"}, rdata_o, last_load);
    end

    @(negedge clock);
    req_valid_i   = 1'b0;
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'($urandom);
    dmem_rdata_i  = rnd64();
    #1;
    check({tag, "_idle_stall"}, stall_o, 0);
    check({tag, "_idle_req"}, dmem_req_o, 0);
    check({tag, "_idle_rvld"}, rdata_valid_o, 0);
    check({tag, "_idle_rdata"}, rdata_o, last_load);
  endtask

  initial begin
    logic [2:0]  f3;
    logic        wen;
    logic [63:0] a;

    reset         = 1'b1;
    req_valid_i   = 1'b0;
    req_wen_i     = 1'b0;
    req_func3_i   = 3'b000;
    req_addr_i    = '0;
    req_wdata_i   = '0;
    dmem_gnt_i    = 1'b0;
    dmem_rvalid_i = 1'b0;
    dmem_rdata_i  = '0;

    @(negedge clock);
    #1;
    check("rst_req", dmem_req_o, 0);
    check("rst_wen", dmem_wen_o, 0);
    check("rst_addr", dmem_addr_o, 0);
    check("rst_wdata", dmem_wdata_o, 0);
    check("rst_wstrb", dmem_wstrb_o, 0);
    check("rst_rdata", rdata_o, 0);
    check("rst_rvld", rdata_valid_o, 0);
    check("rst_misalign", misalign_o, 0);
    check("rst_stall_lo", stall_o, 0);
    req_valid_i = 1'b1;
    #1;
    check("rst_stall_hi", stall_o, 1);
    req_valid_i = 1'b0;
    @(negedge clock);
    reset = 1'b0;

    do_txn("ld_basic", 1'b0, 3'b011, 64'h80000010, rnd64(), 64'h1122334455667788, 0, 0);
    do_txn("lb_sign", 1'b0, 3'b000, 64'h80000005, rnd64(), 64'h0000800000000000, 0, 0);
    check("lb_sign_val", last_load, 64'hFFFFFFFFFFFFFF80);
    do_txn("lbu_zero", 1'b0, 3'b100, 64'h80000005, rnd64(), 64'h0000800000000000, 0, 0);
    check("lbu_zero_val", last_load, 64'h80);
    do_txn("sh_lane3", 1'b1, 3'b001, 64'h80000006, 64'h000000000000ABCD, rnd64(), 0, 0);
    check("sh_keeps_load", rdata_o, 64'h80);
    do_txn("ld_wait", 1'b0, 3'b011, 64'h80000020, rnd64(), 64'hCAFEF00DDEADBEEF, 2, 1);
    do_txn("lw_mis", 1'b0, 3'b010, 64'h80000002, rnd64(), 64'h00000000F1234567, 0, 0);
    do_txn("sw_mis", 1'b1, 3'b010, 64'h80000002, 64'h0000000089ABCDEF, rnd64(), 1, 0);

    // Reset while waiting for the response; a stale rvalid afterwards is dropped.
    @(negedge clock);
    req_valid_i = 1'b1; req_wen_i = 1'b0; req_func3_i = 3'b011;
    req_addr_i = 64'h80000040; dmem_gnt_i = 1'b0; dmem_rvalid_i = 1'b0;
    @(negedge clock);
    dmem_gnt_i = 1'b1;
    @(negedge clock);
    dmem_gnt_i = 1'b0;
    #1;
    check("rstm_in_resp_stall", stall_o, 1);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("rstm_req", dmem_req_o, 0);
    check("rstm_stall_follow", stall_o, 1);
    check("rstm_rdata_clr", rdata_o, 0);
    req_valid_i = 1'b0;
    #1;
    check("rstm_stall_drop", stall_o, 0);
    last_load = '0;
    @(negedge clock);
    reset = 1'b0;
    dmem_rvalid_i = 1'b1;
    dmem_rdata_i = 64'h0123456789ABCDEF;
    #1;
    check("rstm_late_rvld", rdata_valid_o, 0);
    check("rstm_late_stall", stall_o, 0);
    check("rstm_late_rdata", rdata_o, 0);
    dmem_rvalid_i = 1'b0;
    do_txn("after_rst", 1'b0, 3'b110, 64'h80000044, rnd64(), 64'h89ABCDEF00000000, 0, 0);

    for (int i = 0; i < 60; i++) begin
      wen = 1'($urandom);
      f3  = wen ? {1'b0, 2'($urandom)} : 3'($urandom_range(0, 6));
      a   = {32'h0, 32'h80000000 | (32'($urandom) & 32'h0000FFFF)};
      do_txn($sformatf("rnd%0d", i), wen, f3, a, rnd64(), rnd64(),
             int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_040729_mem_lsu.md
# ysyx_040729_mem_lsu

Load/store unit for the MEM stage of the ysyx_040729 pipeline. It takes the effective address and forwarded store data produced by EXE, runs one transaction at a time on a 64-bit aligned data-memory bus with a request/grant/response handshake, and returns sign- or zero-extended load data to WB. While a transaction is outstanding it stalls the upstream pipeline.

## Interface
- DATA_WIDTH, 64, bus and register data width
- ADDR_WIDTH, 64, address width
---
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- req_valid_i  in  1  MEM stage holds a load or store
- req_wen_i  in  1  1 = store, 0 = load
- req_func3_i  in  3  RISC-V funct3: [1:0] = size (B/H/W/D), [2] = unsigned load
- req_addr_i  in  ADDR_WIDTH  effective address (EXE ALU result)
- req_wdata_i  in  DATA_WIDTH  store data (EXE forwarded rs2)
- stall_o  out  1  hold IF/ID/EXE/MEM pipeline registers
- rdata_o  out  DATA_WIDTH  extended load result
- rdata_valid_o  out  1  one-cycle pulse, load completed
- misalign_o  out  1  misaligned access, one-cycle pulse (macro-dependent)
- dmem_req_o  out  1  bus request
- dmem_wen_o  out  1  bus write enable
- dmem_addr_o  out  ADDR_WIDTH  {addr[63:3], 3'b000}
- dmem_wdata_o  out  DATA_WIDTH  lane-replicated store data
- dmem_wstrb_o  out  8  byte strobes
- dmem_gnt_i  in  1  request accepted
- dmem_rvalid_i  in  1  response (load data or store ack)
- dmem_rdata_i  in  DATA_WIDTH  aligned 64-bit read data

## Operation
- FSM IDLE / REQ / RESP; reset state IDLE.
- IDLE: req_valid_i=1 (and not misaligned-trapped) -> capture wen, func3, addr, wdata into internal registers; -> REQ.
- REQ: dmem_req_o=1, all dmem_* driven from captured registers, stable until grant; dmem_gnt_i=1 -> RESP.
- RESP: dmem_req_o=0; dmem_rvalid_i=1 -> IDLE. dmem_rvalid_i ignored in IDLE and REQ.
- stall_o = req_valid_i & ~(state==RESP & dmem_rvalid_i) & ~misalign_o.
- Completion cycle: rdata_o combinational from dmem_rdata_i; rdata_valid_o = RESP & rvalid & ~wen. Otherwise rdata_o holds last registered load result (reset 0).
- Offset off = addr[2:0] (aligned per Configuration). Load: dmem_rdata_i >> (off*8), then extend: func3 000 LB sign 8, 001 LH sign 16, 010 LW sign 32, 011 LD, 100 LBU, 101 LHU, 110 LWU zero-extend.
- Store: wstrb = {0x01,0x03,0x0F,0xFF}[size] << off; wdata = low byte x8 / half x4 / word x2 / doubleword.
- One transaction outstanding; next request sampled only in IDLE, the cycle after completion (upstream has advanced).
- reset mid-transaction: immediately IDLE, dmem_req_o=0, stall_o follows req_valid_i; a late rvalid after reset is ignored.

## Timing
- Reset values: dmem_req_o 0, dmem_wen_o 0, dmem_addr_o 0, dmem_wdata_o 0, dmem_wstrb_o 0, rdata_o 0, rdata_valid_o 0, misalign_o 0, stall_o = req_valid_i.
- Minimum latency: cycle 0 capture (stall 1), cycle 1 REQ with gnt, cycle 2 rvalid (stall 0, data valid) = 3 cycles; each wait cycle on gnt or rvalid adds one.
- gnt and rvalid in the same cycle as REQ: rvalid ignored; only gnt counts.

## Configuration
- YSYX_040729_LSU_MISALIGN_TRAP_EN defined: in IDLE, req_valid_i with addr not aligned to size -> no bus activity, misalign_o=1 for that cycle, stall_o=0, state stays IDLE.
- Undefined: misalign_o tied 0; off = addr[2:0] & ~(size bytes - 1), i.e. access silently aligned down.

## Test plan
- LD addr 0x80000010, gnt cycle 1, rvalid cycle 2 with 0x1122334455667788 -> stall 1,1,0; rdata_o=0x1122334455667788, rdata_valid_o pulse cycle 2.
- LB addr 0x80000005, rdata 0x0000_8000_0000_0000 (byte 5 = 0x80) -> rdata_o=0xFFFFFFFFFFFFFF80; LBU same -> 0x80.
- SH addr 0x80000006, wdata 0xABCD -> dmem_wstrb_o=0xC0, dmem_wdata_o=0xABCDABCDABCDABCD, dmem_wen_o=1, rdata_valid_o stays 0.
- gnt delayed 3 cycles, rvalid delayed 2 -> dmem_req_o/addr stable 3 cycles, stall_o=1 for 6 cycles, released on rvalid cycle.
- reset asserted in RESP, rvalid arrives cycle after deassert with req_valid_i=0 -> no rdata_valid_o, state IDLE.
- LW addr 0x80000002: macro on -> misalign_o pulse, no dmem_req_o; macro off -> access at off 0, wstrb/extract lane 0.
